// File: rtl/scoreboard_hazard_unit.sv
// scoreboard_hazard_unit: tracks in-flight register writes from ID into EX and
// raises stall for load-use, multiply-use, WAW ordering and multiplier
// occupancy hazards that the EX forwarding network cannot yet resolve.
// Optional feature macro: SCOREBOARD_STATS_EN enables the stall_cycles counter;
// when undefined stall_cycles is tied to zero and no counter flop exists.
module scoreboard_hazard_unit #(
  parameter int unsigned MUL_LAT  = 3,
  parameter int unsigned LOAD_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_RegWrite,
  input  logic        id_MemRead,
  input  logic        id_Mul,
  input  logic        id_BL,
  input  logic        flush,
  output logic        stall,
  output logic [30:0] pending,
  output logic        mul_busy,
  output logic [31:0] stall_cycles
);

  localparam int unsigned NUM_TRACKED = 31;
  localparam int unsigned NUM_IDX     = 32;
  localparam int unsigned REG_IDX_W   = 5;
  localparam int unsigned CNT_W       = 3;
  localparam int unsigned STATS_W     = 32;

  localparam logic [REG_IDX_W-1:0] XZR_IDX = REG_IDX_W'(31);
  localparam logic [REG_IDX_W-1:0] LR_IDX  = REG_IDX_W'(30);
  localparam logic [CNT_W-1:0]     MUL_NL  = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0]     LOAD_NL = CNT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);

  // Per-register countdown until the outstanding result becomes forwardable
  logic [CNT_W-1:0] cnt_q [NUM_TRACKED];
  logic [CNT_W-1:0] cnt_d [NUM_TRACKED];
  logic [CNT_W-1:0] mul_cnt_q;
  logic [CNT_W-1:0] mul_cnt_d;

  // Full 32-entry view so any 5-bit index is in range; X31 always reads zero
  logic [CNT_W-1:0] cnt_view [NUM_IDX];

  logic                 wr_en;
  logic [REG_IDX_W-1:0] dst;
  logic [CNT_W-1:0]     new_lat;
  logic                 id_active;
  logic                 haz_rs1;
  logic                 haz_rs2;
  logic                 haz_waw;
  logic                 haz_mul;
  logic                 issue;
  logic                 track_dst;

  // Expose counters through an index-safe view with XZR pinned to zero
  always_comb begin
    cnt_view[NUM_IDX-1] = '0;
    for (int r = 0; r < int'(NUM_TRACKED); r++) begin
      cnt_view[r] = cnt_q[r];
    end
  end

  // Decode the ID instruction's effective destination and result latency
  always_comb begin
    wr_en   = id_RegWrite | id_BL;
    dst     = id_BL ? LR_IDX : id_rd;
    new_lat = '0;
    if (id_Mul) begin
      new_lat = MUL_NL;
    end else if (id_MemRead) begin
      new_lat = LOAD_NL;
    end
  end

  // Hazard detection; a flushed or invalid ID slot never stalls
  always_comb begin
    id_active = id_valid & ~flush;
    haz_rs1   = id_use_rs1 & (id_rs1 != XZR_IDX) & (cnt_view[id_rs1] != '0);
    haz_rs2   = id_use_rs2 & (id_rs2 != XZR_IDX) & (cnt_view[id_rs2] != '0);
    haz_waw   = wr_en & (dst != XZR_IDX) & (cnt_view[dst] > new_lat);
    haz_mul   = id_Mul & (mul_cnt_q > CNT_ONE);
    stall     = id_active & (haz_rs1 | haz_rs2 | haz_waw | haz_mul);
    issue     = id_active & ~stall;
    track_dst = issue & wr_en & (dst != XZR_IDX);
  end

  // Next-state: decrement outstanding counts, then let an accepted issue overwrite
  always_comb begin
    for (int r = 0; r < int'(NUM_TRACKED); r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? (cnt_q[r] - CNT_ONE) : cnt_q[r];
      if (track_dst && (dst == REG_IDX_W'(r))) begin
        cnt_d[r] = new_lat;
      end
    end
    mul_cnt_d = (mul_cnt_q != '0) ? (mul_cnt_q - CNT_ONE) : mul_cnt_q;
    if (issue && id_Mul) begin
      mul_cnt_d = MUL_NL;
    end
  end

  // Scoreboard state registers; reset discards all in-flight tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < int'(NUM_TRACKED); r++) begin
        cnt_q[r] <= '0;
      end
      mul_cnt_q <= '0;
    end else begin
      for (int r = 0; r < int'(NUM_TRACKED); r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      mul_cnt_q <= mul_cnt_d;
    end
  end

  // Status outputs derived straight from the registered counters
  always_comb begin
    for (int r = 0; r < int'(NUM_TRACKED); r++) begin
      pending[r] = (cnt_q[r] != '0);
    end
    mul_busy = (mul_cnt_q != '0);
  end

`ifdef SCOREBOARD_STATS_EN
  logic [STATS_W-1:0] stall_cycles_q;

  // Count every clock on which stall is asserted; wraps naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= '0;
    end else if (stall) begin
      stall_cycles_q <= stall_cycles_q + STATS_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Self-checking bench for scoreboard_hazard_unit: directed test-plan sequences
// followed by randomized traffic checked against a ready-time reference model.
module tb_scoreboard_hazard_unit;

  localparam int unsigned MUL_LAT  = 3;
  localparam int unsigned LOAD_LAT = 2;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  id_rd;
  logic        id_RegWrite;
  logic        id_MemRead;
  logic        id_Mul;
  logic        id_BL;
  logic        flush;
  logic        stall;
  logic [30:0] pending;
  logic        mul_busy;
  logic [31:0] stall_cycles;

  scoreboard_hazard_unit #(
    .MUL_LAT  (MUL_LAT),
    .LOAD_LAT (LOAD_LAT)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_RegWrite  (id_RegWrite),
    .id_MemRead   (id_MemRead),
    .id_Mul       (id_Mul),
    .id_BL        (id_BL),
    .flush        (flush),
    .stall        (stall),
    .pending      (pending),
    .mul_busy     (mul_busy),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: absolute cycle at which each result becomes forwardable
  longint      now;
  longint      ready_at [32];
  longint      mul_free_at;
  logic [31:0] m_stats;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint remaining(input logic [4:0] r);
    if (r == 5'd31) return 0;
    if (ready_at[r] > now) return ready_at[r] - now;
    return 0;
  endfunction

  function automatic longint mul_remaining();
    if (mul_free_at > now) return mul_free_at - now;
    return 0;
  endfunction

  function automatic logic [30:0] model_pending();
    logic [30:0] p;
    for (int r = 0; r < 31; r++) p[r] = (remaining(5'(r)) > 0);
    return p;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) ready_at[r] = 0;
    mul_free_at = 0;
    m_stats     = '0;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mul,
                       input logic bl, input logic fl);
    id_valid    = v;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_use_rs1  = u1;
    id_use_rs2  = u2;
    id_rd       = rd;
    id_RegWrite = rw;
    id_MemRead  = mr;
    id_Mul      = mul;
    id_BL       = bl;
    flush       = fl;
  endtask

  task automatic drive_idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One ID cycle: drive, compare against the model, then advance over the edge.
  // exp_stall >= 0 additionally pins stall to a hand-derived value.
  task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic rw, input logic mr, input logic mul,
                      input logic bl, input logic fl, input int exp_stall);
    logic       act, w, m_stall;
    logic [4:0] d;
    longint     nl;
    @(negedge clk);
    drive(v, rs1, rs2, u1, u2, rd, rw, mr, mul, bl, fl);
    #1;
    act = v & ~fl;
    w   = rw | bl;
    d   = bl ? 5'd30 : rd;
    nl  = mul ? longint'(MUL_LAT - 1) : (mr ? longint'(LOAD_LAT - 1) : 0);
    m_stall = act && ((u1 && rs1 != 5'd31 && remaining(rs1) > 0) ||
                      (u2 && rs2 != 5'd31 && remaining(rs2) > 0) ||
                      (w && d != 5'd31 && remaining(d) > nl) ||
                      (mul && mul_remaining() > 1));
    if (exp_stall >= 0) check_eq("plan_stall", 32'(stall), 32'(exp_stall));
    check_eq("stall", 32'(stall), 32'(m_stall));
    check_eq("pending", 32'(pending), 32'(model_pending()));
    check_eq("mul_busy", 32'(mul_busy), 32'(mul_remaining() > 0));
    check_eq("stall_cycles", stall_cycles, m_stats);
    @(posedge clk);
`ifdef SCOREBOARD_STATS_EN
    if (m_stall) m_stats = m_stats + 32'd1;
`endif
    if (act && !m_stall) begin
      if (w && d != 5'd31) ready_at[d] = now + 1 + nl;
      if (mul) mul_free_at = now + longint'(MUL_LAT);
    end
    now++;
  endtask

  // Pull reset low between edges and confirm tracking vanishes immediately
  task automatic async_reset_check();
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_pending", 32'(pending), 32'd0);
    check_eq("rst_mul_busy", 32'(mul_busy), 32'd0);
    check_eq("rst_stall_cycles", stall_cycles, 32'd0);
    model_clear();
    drive_idle();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [4:0] rand_reg();
    logic [4:0] tbl [8];
    tbl[0] = 5'd1; tbl[1] = 5'd2;  tbl[2] = 5'd3;  tbl[3] = 5'd4;
    tbl[4] = 5'd5; tbl[5] = 5'd30; tbl[6] = 5'd31; tbl[7] = 5'($urandom_range(0, 31));
    return tbl[$urandom_range(0, 7)];
  endfunction

  initial begin
    now = 0;
    model_clear();
    rst_n = 1'b0;
    drive_idle();
    #2;
    check_eq("reset_stall", 32'(stall), 32'd0);
    check_eq("reset_pending", 32'(pending), 32'd0);
    check_eq("reset_mul_busy", 32'(mul_busy), 32'd0);
    check_eq("reset_stall_cycles", stall_cycles, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    //   v  rs1 rs2 u1 u2 rd rw mr mul bl fl exp
    // Load-use: LDUR X5 then ADD X6,X5,X1 stalls exactly once
    step(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0);
    step(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 1);
    step(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("lu_pending5", 32'(pending[5]), 32'd0);
    // ALU chain: ADD X2 then SUB X3,X2,X2 never stalls
    step(1, 1, 1, 1, 1, 2, 1, 0, 0, 0, 0, 0);
    step(1, 2, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0);
    check_eq("alu_pending2", 32'(pending[2]), 32'd0);
    // Multiply: dependent ADD on X7 stalls twice
    step(1, 1, 2, 1, 1, 7, 1, 0, 1, 0, 0, 0);
    step(1, 7, 1, 1, 1, 8, 1, 0, 0, 0, 0, 1);
    step(1, 7, 1, 1, 1, 8, 1, 0, 0, 0, 0, 1);
    step(1, 7, 1, 1, 1, 8, 1, 0, 0, 0, 0, 0);
    // Back-to-back multiplies one cycle apart: one stall, multiplier busy
    step(1, 1, 2, 1, 1, 10, 1, 0, 1, 0, 0, 0);
    step(1, 1, 2, 1, 1, 11, 1, 0, 1, 0, 0, 1);
    check_eq("mul_busy_hold", 32'(mul_busy), 32'd1);
    step(1, 1, 2, 1, 1, 11, 1, 0, 1, 0, 0, 0);
    // BL then reader of X30: no stall
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 30, 0, 1, 0, 12, 1, 0, 0, 0, 0, 0);
    // LDUR X31 then reader of X31: no stall, nothing pending
    repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 31, 1, 1, 0, 0, 0, 0);
    step(1, 31, 31, 1, 1, 13, 1, 0, 0, 0, 0, 0);
    check_eq("xzr_pending", 32'(pending), 32'd0);
    // MUL X4, flushed ADD X9,X4, then WAW ADD X4 stalls once
    step(1, 1, 2, 1, 1, 4, 1, 0, 1, 0, 0, 0);
    step(1, 4, 0, 1, 0, 9, 1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    check_eq("waw_pending4", 32'(pending[4]), 32'd0);
    // Async reset while cnt[5] = 1 with a dependent reader in ID
    step(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 0);
    #1;
    check_eq("pre_rst_stall", 32'(stall), 32'd1);
    async_reset_check();

    // Randomized traffic, with one mid-run asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      logic v, fl, mul, mr, bl;
      v   = ($urandom_range(0, 99) < 85);
      fl  = ($urandom_range(0, 99) < 10);
      mul = ($urandom_range(0, 99) < 20);
      mr  = !mul && ($urandom_range(0, 99) < 30);
      bl  = !mul && !mr && ($urandom_range(0, 99) < 10);
      step(v, rand_reg(), rand_reg(), 1'($urandom), 1'($urandom), rand_reg(),
           ($urandom_range(0, 99) < 80), mr, mul, bl, fl, -1);
      if (i == 1500) begin
        @(negedge clk);
        async_reset_check();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
